sd_cmd_resp_serializer: RTL and testbench

- Card-side synthesizable driver for SD CMD-line responses; replaces the fixed 48-bit parallel-to-serial response generator in the host test environment.
- Supports short (R1/R3/R6/R7, 48-bit) and long (R2, 136-bit) frames.
- Programmable Ncr turnaround delay, optional on-the-fly CRC7 generation, and abort.
- Sits between the card-model stimulus and the host's cmd_from_sd input, clocked by the card clock.

---
 rtl/sd_cmd_resp_serializer_pkg.sv | 20 ++
 rtl/sd_crc7_serial.sv | 25 ++
 rtl/sd_cmd_resp_serializer.sv | 135 +++++++++++++
 tb/tb_sd_cmd_resp_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_resp_serializer_pkg.sv
// Shared constants and state encoding for the SD CMD-line response serializer
// and its CRC7 helper.
package sd_cmd_resp_serializer_pkg;

    localparam logic [6:0]  Crc7Poly     = 7'h09;
    localparam int unsigned ShortFrameW  = 48;
    localparam int unsigned LongFrameW   = 136;
    // Long (R2) frames exclude the 8-bit header from the CRC.
    localparam int unsigned LongCrcTop   = 127;
    localparam int unsigned CrcLowBit    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StShift,
        StCrc,
        StEndb
    } state_e;

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB-first; clear has priority over enable.
module sd_crc7_serial
    import sd_cmd_resp_serializer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       bit_in,
    input  logic       enable,
    input  logic       clear,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = bit_in ^ crc[6];

    always_ff @(posedge CLK) begin
        if (!RESET || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? Crc7Poly : 7'h00);
        end
    end

endmodule

// File: rtl/sd_cmd_resp_serializer.sv
// Card-side SD CMD response serializer: 48/136-bit frames, Ncr delay,
// optional on-the-fly CRC7 and abort. All outputs are registered.
module sd_cmd_resp_serializer
    import sd_cmd_resp_serializer_pkg::*;
#(
    parameter int unsigned LongW     = LongFrameW,
    parameter int unsigned ShortW    = ShortFrameW,
    parameter int unsigned NcrW      = 6,
    parameter logic        IdleLevel = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             resp_long,
    input  logic             crc_auto,
    input  logic [NcrW-1:0]  ncr_cycles,
    input  logic [LongW-1:0] resp_data,
    input  logic             abort,
    output logic             cmd_out,
    output logic             cmd_oe,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(LongW);

    state_e           state_q;
    logic [LongW-1:0] sr_q;
    logic [CntW-1:0]  bit_q;
    logic [NcrW-1:0]  ncr_q;
    logic             long_q;
    logic             crc_auto_q;
    logic             end_q;
    logic             crc_clear;
    logic             crc_en;
    logic [6:0]       crc;

    // The CRC only accumulates in SHIFT; holding it clear elsewhere gives a
    // fresh register on every SHIFT entry.
    assign crc_clear = (state_q == StIdle) || (state_q == StWait);
    assign crc_en    = (state_q == StShift) && (bit_q >= CntW'(CrcLowBit)) &&
                       (!long_q || (bit_q <= CntW'(LongCrcTop)));

    sd_crc7_serial u_crc7 (
        .CLK    (CLK),
        .RESET  (RESET),
        .bit_in (sr_q[LongW-1]),
        .enable (crc_en),
        .clear  (crc_clear),
        .crc    (crc)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            bit_q      <= '0;
            ncr_q      <= '0;
            long_q     <= 1'b0;
            crc_auto_q <= 1'b0;
            end_q      <= 1'b0;
            cmd_out    <= IdleLevel;
            cmd_oe     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            state_q <= StIdle;
            end_q   <= 1'b0;
            cmd_out <= IdleLevel;
            cmd_oe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // end_q marks the cycle the end bit is on the line.
                    cmd_out <= IdleLevel;
                    cmd_oe  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= end_q;
                    end_q   <= 1'b0;
                    if (start && !busy) begin
                        sr_q       <= resp_long ? resp_data :
                                      {resp_data[ShortW-1:0], {(LongW-ShortW){1'b0}}};
                        bit_q      <= resp_long ? CntW'(LongW - 1) : CntW'(ShortW - 1);
                        long_q     <= resp_long;
                        crc_auto_q <= crc_auto;
                        ncr_q      <= ncr_cycles;
                        busy       <= 1'b1;
                        state_q    <= (ncr_cycles != '0) ? StWait : StShift;
                    end
                end
                StWait: begin
                    cmd_out <= IdleLevel;
                    cmd_oe  <= 1'b0;
                    ncr_q   <= ncr_q - 1'b1;
                    if (ncr_q == NcrW'(1)) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    cmd_out <= sr_q[LongW-1];
                    cmd_oe  <= 1'b1;
                    sr_q    <= sr_q << 1;
                    bit_q   <= bit_q - 1'b1;
                    if (crc_auto_q && (bit_q == CntW'(CrcLowBit))) begin
                        state_q <= StCrc;
                    end else if (bit_q == CntW'(1)) begin
                        state_q <= StEndb;
                    end
                end
                StCrc: begin
                    // bit_q runs 7..1 here, selecting crc[6]..crc[0].
                    cmd_out <= crc[3'(bit_q - 1'b1)];
                    cmd_oe  <= 1'b1;
                    bit_q   <= bit_q - 1'b1;
                    if (bit_q == CntW'(1)) begin
                        state_q <= StEndb;
                    end
                end
                StEndb: begin
                    cmd_out <= crc_auto_q ? 1'b1 : sr_q[LongW-1];
                    cmd_oe  <= 1'b1;
                    end_q   <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp_serializer.sv
// Self-checking bench for sd_cmd_resp_serializer: scoreboard of expected
// serial bits plus latency, pulse-width, abort, reset and overlap checks.
module tb_sd_cmd_resp_serializer;

    localparam int unsigned LongW  = 136;
    localparam int unsigned ShortW = 48;
    localparam int unsigned NcrW   = 6;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             start = 1'b0;
    logic             resp_long = 1'b0;
    logic             crc_auto = 1'b0;
    logic [NcrW-1:0]  ncr_cycles = '0;
    logic [LongW-1:0] resp_data = '0;
    logic             abort = 1'b0;
    logic             cmd_out;
    logic             cmd_oe;
    logic             busy;
    logic             done;
    logic             cmd_from_sd;

    int               n_checks = 0;
    int               n_fail = 0;
    logic             exp_q[$];
    logic [LongW-1:0] rx_frame = '0;
    int               rx_cnt = 0;

    assign cmd_from_sd = cmd_oe ? cmd_out : 1'b1;

    always #5 CLK = ~CLK;

    sd_cmd_resp_serializer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .resp_long  (resp_long),
        .crc_auto   (crc_auto),
        .ncr_cycles (ncr_cycles),
        .resp_data  (resp_data),
        .abort      (abort),
        .cmd_out    (cmd_out),
        .cmd_oe     (cmd_oe),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_val(input string tag, input logic [LongW-1:0] obs,
                             input logic [LongW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC7 as polynomial long division of the message times x^7.
    function automatic logic [6:0] crc7_model(input logic [LongW-1:0] f, input int hi,
                                              input int lo);
        logic [7:0] rem;
        rem = '0;
        for (int i = hi; i >= lo - 7; i--) begin
            rem = {rem[6:0], (i >= lo) ? f[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic logic [LongW-1:0] model_frame(input logic lng, input logic crc_on,
                                                     input logic [LongW-1:0] data);
        logic [LongW-1:0] f;
        f = lng ? data : {{(LongW-ShortW){1'b0}}, data[ShortW-1:0]};
        if (crc_on) begin
            f[7:1] = crc7_model(f, lng ? 127 : 47, 8);
            f[0]   = 1'b1;
        end
        return f;
    endfunction

    // Scoreboard side: every driven bit is popped and compared.
    always @(negedge CLK) begin
        logic e;
        if (cmd_oe) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = ~cmd_from_sd;
            check_val("bit", {{(LongW-1){1'b0}}, cmd_from_sd}, {{(LongW-1){1'b0}}, e});
            rx_frame = {rx_frame[LongW-2:0], cmd_from_sd};
            rx_cnt++;
        end
    end

    task automatic kick(input logic lng, input logic crc_on, input logic [NcrW-1:0] ncr,
                        input logic [LongW-1:0] data, input logic [LongW-1:0] exp_frame);
        int w;
        w = lng ? LongW : ShortW;
        exp_q.delete();
        for (int i = w - 1; i >= 0; i--) exp_q.push_back(exp_frame[i]);
        @(posedge CLK); #1;
        start = 1'b1; resp_long = lng; crc_auto = crc_on; ncr_cycles = ncr; resp_data = data;
        @(posedge CLK); #1;
        // Latched values must survive input changes.
        start = 1'b0; resp_long = ~lng; crc_auto = ~crc_on; ncr_cycles = ~ncr;
        resp_data = ~data;
    endtask

    task automatic run_frame(input string tag, input logic lng, input logic crc_on,
                             input logic [NcrW-1:0] ncr, input logic [LongW-1:0] data,
                             input logic [LongW-1:0] exp_frame, input bit overlap);
        int w, first_idx, done_idx, oe_cnt, base;
        logic [LongW-1:0] mask;
        w = lng ? LongW : ShortW;
        first_idx = -1; done_idx = -1; oe_cnt = 0; base = rx_cnt;
        mask = lng ? '1 : {{(LongW-ShortW){1'b0}}, {ShortW{1'b1}}};
        kick(lng, crc_on, ncr, data, exp_frame);
        for (int idx = 0; idx < w + int'(ncr) + 8; idx++) begin
            @(negedge CLK);
            if (idx == 0) check_val({tag, "_busy"}, LongW'(busy), LongW'(1));
            if (cmd_oe) begin
                oe_cnt++;
                if (first_idx < 0) first_idx = idx;
            end
            if (done) begin
                done_idx = idx;
                break;
            end
            start = (overlap && idx == 3);
        end
        start = 1'b0;
        check_val({tag, "_first"}, LongW'(first_idx), LongW'(int'(ncr) + 1));
        check_val({tag, "_oe_cnt"}, LongW'(oe_cnt), LongW'(w));
        check_val({tag, "_done_at"}, LongW'(done_idx), LongW'(int'(ncr) + w + 1));
        check_val({tag, "_frame"}, rx_frame & mask, exp_frame);
        check_val({tag, "_rx_cnt"}, LongW'(rx_cnt - base), LongW'(w));
        check_val({tag, "_q_left"}, LongW'(exp_q.size()), LongW'(0));
        check_val({tag, "_busy_end"}, LongW'(busy), LongW'(0));
        @(negedge CLK);
        check_val({tag, "_done_1cyc"}, LongW'(done), LongW'(0));
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_oe"}, LongW'(cmd_oe), LongW'(0));
        check_val({tag, "_out"}, LongW'(cmd_out), LongW'(1));
        check_val({tag, "_busy"}, LongW'(busy), LongW'(0));
        check_val({tag, "_done"}, LongW'(done), LongW'(0));
    endtask

    initial begin
        logic [LongW-1:0] d;
        int base, done_seen;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_idle("reset");
        RESET = 1'b1;

        run_frame("cmd0", 1'b0, 1'b1, 6'd2, 48'h4000_0000_0000, 48'h4000_0000_0095, 1'b0);
        run_frame("cmd8", 1'b0, 1'b1, 6'd0, 48'h4800_0001_AA00, 48'h4800_0001_AA87, 1'b0);
        run_frame("pass", 1'b0, 1'b0, 6'd5, 48'h19FA_FADB_DBF3, 48'h19FA_FADB_DBF3, 1'b0);

        for (int i = 0; i < LongW; i++) d[i] = 1'($urandom_range(0, 1));
        run_frame("long", 1'b1, 1'b1, 6'd3, d, model_frame(1'b1, 1'b1, d), 1'b0);
        for (int i = 0; i < LongW; i++) d[i] = 1'($urandom_range(0, 1));
        run_frame("long_pass", 1'b1, 1'b0, 6'd1, d, d, 1'b0);
        for (int i = 0; i < LongW; i++) d[i] = 1'($urandom_range(0, 1));
        run_frame("rand_short", 1'b0, 1'b1, 6'd4, d, model_frame(1'b0, 1'b1, d), 1'b0);
        run_frame("ncr_max", 1'b0, 1'b0, 6'h3F, 48'hA5C3_0F96_3C5A, 48'hA5C3_0F96_3C5A, 1'b0);

        // Abort after 20 bits, then a clean restart.
        base = rx_cnt;
        kick(1'b0, 1'b1, 6'd0, 48'h4000_0000_0000, 48'h4000_0000_0095);
        for (int i = 0; i < 100 && (rx_cnt - base) < 20; i++) begin
            @(negedge CLK); #1;
        end
        check_val("abort_reach", LongW'(rx_cnt - base), LongW'(20));
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        @(negedge CLK);
        check_idle("abort");
        #1 exp_q.delete();
        done_seen = 0;
        repeat (60) begin
            @(negedge CLK);
            if (done) done_seen++;
        end
        check_val("abort_no_done", LongW'(done_seen), LongW'(0));
        run_frame("restart", 1'b0, 1'b1, 6'd0, 48'h4000_0000_0000, 48'h4000_0000_0095, 1'b0);

        // Reset mid-SHIFT.
        base = rx_cnt;
        kick(1'b0, 1'b0, 6'd1, 48'h1234_5678_9ABC, 48'h1234_5678_9ABC);
        for (int i = 0; i < 100 && (rx_cnt - base) < 10; i++) begin
            @(negedge CLK); #1;
        end
        check_val("rst_reach", LongW'(rx_cnt - base), LongW'(10));
        RESET = 1'b0;
        @(negedge CLK);
        check_idle("rst_mid");
        RESET = 1'b1;
        #1 exp_q.delete();
        run_frame("after_rst", 1'b0, 1'b1, 6'd1, 48'h5100_0000_0000, 48'h5100_0000_0055, 1'b0);

        // Start while busy must not queue a second frame.
        run_frame("overlap", 1'b0, 1'b1, 6'd2, 48'h4800_0001_AA00, 48'h4800_0001_AA87, 1'b1);
        base = rx_cnt;
        repeat (120) @(negedge CLK);
        check_val("overlap_no_2nd", LongW'(rx_cnt - base), LongW'(0));

        // Abort and start together in IDLE: abort wins.
        base = rx_cnt;
        @(posedge CLK); #1;
        start = 1'b1; abort = 1'b1; resp_long = 1'b0; crc_auto = 1'b1; ncr_cycles = '0;
        @(posedge CLK); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        check_val("abort_start_busy", LongW'(busy), LongW'(0));
        repeat (60) @(negedge CLK);
        check_val("abort_start_bits", LongW'(rx_cnt - base), LongW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1);
    end

endmodule
